// File: rtl/alu_operand_entry.sv
// Operand entry front end: synchronizes and debounces the board switches and buttons,
// then sequences capture of operand A, operand B and the ALU select code.
module alu_operand_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DATA_W          = 4
) (
  input  logic              clk_100Mhz,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw,
  input  logic              btn_enter,
  input  logic              btn_clear,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] alu_sel,
  output logic              operands_valid,
  output logic              load_strobe,
  output logic [1:0]        entry_state
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ENTER_A  = 2'b00,
    ENTER_B  = 2'b01,
    ENTER_OP = 2'b10,
    READY    = 2'b11
  } state_t;

  // Button bit 0 is enter, bit 1 is clear.
  logic [DATA_W-1:0] sw_meta_r, sw_sync_r;
  logic [1:0]        btn_meta_r, btn_sync_r;
  logic [1:0]        db_r, db_prev_r;
  logic [CNT_W-1:0]  cnt_r [2];

  logic              press_enter_s, press_clear_s;
  state_t            state_r, state_next_s;
  logic [DATA_W-1:0] data_a_r, data_b_r, alu_sel_r;
  logic [DATA_W-1:0] data_a_next_s, data_b_next_s, alu_sel_next_s;
  logic              valid_r, valid_next_s;
  logic              strobe_r, strobe_next_s;

  // Two-flop synchronizers for the asynchronous board inputs.
  always_ff @(posedge clk_100Mhz or negedge reset) begin
    if (!reset) begin
      sw_meta_r  <= '0;
      sw_sync_r  <= '0;
      btn_meta_r <= '0;
      btn_sync_r <= '0;
    end else begin
      sw_meta_r  <= sw;
      sw_sync_r  <= sw_meta_r;
      btn_meta_r <= {btn_clear, btn_enter};
      btn_sync_r <= btn_meta_r;
    end
  end

  // Per-button debounce: level flips only after DEBOUNCE_CYCLES consecutive mismatches.
  always_ff @(posedge clk_100Mhz or negedge reset) begin
    if (!reset) begin
      db_r      <= '0;
      db_prev_r <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      db_prev_r <= db_r;
      for (int i = 0; i < 2; i++) begin
        if (btn_sync_r[i] == db_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CNT_LAST) begin
          db_r[i]  <= ~db_r[i];
          cnt_r[i] <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

  assign press_enter_s = db_r[0] & ~db_prev_r[0];
  assign press_clear_s = db_r[1] & ~db_prev_r[1];

  // Entry sequencing; clear outranks enter when both land in the same cycle.
  always_comb begin
    state_next_s   = state_r;
    data_a_next_s  = data_a_r;
    data_b_next_s  = data_b_r;
    alu_sel_next_s = alu_sel_r;
    strobe_next_s  = 1'b0;
    if (press_clear_s) begin
      state_next_s   = ENTER_A;
      data_a_next_s  = '0;
      data_b_next_s  = '0;
      alu_sel_next_s = '0;
    end else if (press_enter_s) begin
      case (state_r)
        ENTER_A: begin
          data_a_next_s = sw_sync_r;
          state_next_s  = ENTER_B;
        end
        ENTER_B: begin
          data_b_next_s = sw_sync_r;
          state_next_s  = ENTER_OP;
        end
        ENTER_OP: begin
          alu_sel_next_s = sw_sync_r;
          strobe_next_s  = 1'b1;
          state_next_s   = READY;
        end
        READY: begin
          state_next_s = ENTER_A;
        end
        default: begin
          state_next_s = ENTER_A;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
    valid_next_s = (state_next_s == READY);
  end

  // State and output registers.
  always_ff @(posedge clk_100Mhz or negedge reset) begin
    if (!reset) begin
      state_r   <= ENTER_A;
      data_a_r  <= '0;
      data_b_r  <= '0;
      alu_sel_r <= '0;
      valid_r   <= 1'b0;
      strobe_r  <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      data_a_r  <= data_a_next_s;
      data_b_r  <= data_b_next_s;
      alu_sel_r <= alu_sel_next_s;
      valid_r   <= valid_next_s;
      strobe_r  <= strobe_next_s;
    end
  end

  assign data_a         = data_a_r;
  assign data_b         = data_b_r;
  assign alu_sel        = alu_sel_r;
  assign operands_valid = valid_r;
  assign load_strobe    = strobe_r;
  assign entry_state    = state_r;

endmodule

// File: tb/tb_alu_operand_entry.sv
// Directed self-checking bench for alu_operand_entry with a short debounce window.
module tb_alu_operand_entry;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw;
  logic       btn_enter, btn_clear;
  logic [3:0] data_a, data_b, alu_sel;
  logic       operands_valid, load_strobe;
  logic [1:0] entry_state;

  int n_checks = 0;
  int n_fail   = 0;
  int strobes;

  alu_operand_entry #(.DEBOUNCE_CYCLES(4), .DATA_W(4)) dut (
    .clk_100Mhz     (clk),
    .reset          (reset),
    .sw             (sw),
    .btn_enter      (btn_enter),
    .btn_clear      (btn_clear),
    .data_a         (data_a),
    .data_b         (data_b),
    .alu_sel        (alu_sel),
    .operands_valid (operands_valid),
    .load_strobe    (load_strobe),
    .entry_state    (entry_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int hold, input int rel);
    btn_enter = 1'b1;
    cycles(hold);
    btn_enter = 1'b0;
    cycles(rel);
  endtask

  function automatic logic [31:0] all_out();
    return {16'h0000, data_a, data_b, alu_sel, operands_valid, load_strobe, entry_state};
  endfunction

  initial begin
    reset = 1'b0; sw = 4'h0; btn_enter = 1'b0; btn_clear = 1'b0;
    cycles(3);
    check_eq("reset_outputs", all_out(), 32'h0);
    reset = 1'b1;

    // Idle after reset
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_eq("idle_outputs", all_out(), 32'h0);
    end

    // Full entry A=3, B=5, op=1
    sw = 4'h3; press(10, 10);
    check_eq("a_captured", {28'h0, data_a}, 32'h3);
    check_eq("state_b", {30'h0, entry_state}, 32'h1);
    sw = 4'h5; press(10, 10);
    check_eq("b_captured", {28'h0, data_b}, 32'h5);
    check_eq("state_op", {30'h0, entry_state}, 32'h2);
    sw = 4'h1; btn_enter = 1'b1; strobes = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (load_strobe) begin
        strobes++;
        check_eq("valid_with_strobe", {31'h0, operands_valid}, 32'h1);
      end
    end
    btn_enter = 1'b0; cycles(10);
    check_eq("strobe_once", strobes, 32'd1);
    check_eq("ready_outputs", all_out(), {16'h0, 4'h3, 4'h5, 4'h1, 1'b1, 1'b0, 2'b11});

    // Enter in READY restarts and keeps old values
    sw = 4'h0; press(10, 10);
    check_eq("restart_outputs", all_out(), {16'h0, 4'h3, 4'h5, 4'h1, 1'b0, 1'b0, 2'b00});

    // Long hold advances only once
    sw = 4'h3; press(40, 10);
    check_eq("hold_state", {30'h0, entry_state}, 32'h1);
    check_eq("hold_a", {28'h0, data_a}, 32'h3);

    // Bouncing enter: one capture 6 cycles after going stable
    sw = 4'h5;
    for (int i = 0; i < 6; i++) begin
      btn_enter = (i % 2 == 0);
      cycles(2);
    end
    btn_enter = 1'b1;
    cycles(6);
    check_eq("bounce_not_yet", {30'h0, entry_state}, 32'h1);
    cycles(1);
    check_eq("bounce_capture", {30'h0, entry_state}, 32'h2);
    check_eq("bounce_b", {28'h0, data_b}, 32'h5);
    cycles(5); btn_enter = 1'b0; cycles(10);
    check_eq("bounce_single", {30'h0, entry_state}, 32'h2);

    // Three-cycle glitch is ignored
    sw = 4'h2;
    btn_enter = 1'b1; cycles(3); btn_enter = 1'b0; cycles(20);
    check_eq("glitch_state", {30'h0, entry_state}, 32'h2);
    check_eq("glitch_sel", {28'h0, alu_sel}, 32'h1);

    // Clear together with enter in ENTER_OP
    sw = 4'h7; btn_enter = 1'b1; btn_clear = 1'b1; strobes = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (load_strobe) strobes++;
    end
    btn_enter = 1'b0; btn_clear = 1'b0; cycles(10);
    check_eq("clear_no_strobe", strobes, 32'd0);
    check_eq("clear_outputs", all_out(), 32'h0);

    // Async reset mid-debounce in ENTER_B
    sw = 4'h6; press(10, 10);
    check_eq("pre_reset_a", {28'h0, data_a}, 32'h6);
    check_eq("pre_reset_state", {30'h0, entry_state}, 32'h1);
    sw = 4'h8; btn_enter = 1'b1; cycles(3);
    #1 reset = 1'b0;
    #1 check_eq("async_reset_outputs", all_out(), 32'h0);
    btn_enter = 1'b0;
    cycles(3);
    reset = 1'b1;
    cycles(10);
    check_eq("post_reset_idle", all_out(), 32'h0);
    sw = 4'hA; press(10, 10);
    check_eq("post_reset_outputs", all_out(), {16'h0, 4'hA, 4'h0, 4'h0, 1'b0, 1'b0, 2'b01});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
